// File: rtl/ps2_pkg.sv
// Shared types, prefix codes and the scan-code-set-2 to Chip-8 keypad map.
package ps2_pkg;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Returns {hit, key}; hit=0 means the code is not on the keypad.
  function automatic logic [4:0] sc_to_key(input logic [7:0] sc);
    logic [4:0] res;
    res = 5'h00;
    case (sc)
      8'h16: res = {1'b1, 4'h1};
      8'h1E: res = {1'b1, 4'h2};
      8'h26: res = {1'b1, 4'h3};
      8'h25: res = {1'b1, 4'hC};
      8'h15: res = {1'b1, 4'h4};
      8'h1D: res = {1'b1, 4'h5};
      8'h24: res = {1'b1, 4'h6};
      8'h2D: res = {1'b1, 4'hD};
      8'h1C: res = {1'b1, 4'h7};
      8'h1B: res = {1'b1, 4'h8};
      8'h23: res = {1'b1, 4'h9};
      8'h2B: res = {1'b1, 4'hE};
      8'h1A: res = {1'b1, 4'hA};
      8'h22: res = {1'b1, 4'h0};
      8'h21: res = {1'b1, 4'hB};
      8'h2A: res = {1'b1, 4'hF};
      default: res = 5'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, 11-bit frame FSM and
// mid-frame timeout. Emits one-cycle scan_valid / frame_err strobes.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       scan_valid_o,
  output logic [7:0] scan_byte_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntExp = CntW'(TIMEOUT_CYCLES - 1);

  logic [1:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q;
  logic       fall, data;

  frame_state_e    state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [7:0]      byte_q, byte_d;

  // Synchronisers reset to the idle-high line level so release gives no false edge.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign data = data_sync_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (fall || state_q == StIdle) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    unique case (state_q)
      StIdle: begin
        if (fall && !data) begin
          bit_cnt_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          parity_d = data;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          if (data && (^shift_q ^ parity_q)) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A fall on the expiry cycle keeps the frame alive.
    if (state_q != StIdle && !fall && cnt_q == CntExp) begin
      err_d   = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      byte_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      byte_q    <= byte_d;
    end
  end

  assign scan_valid_o = valid_q;
  assign scan_byte_o  = byte_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard to Chip-8 hex keypad: tracks F0/E0 prefixes and keeps a
// per-key held bitmap, strobing key_event only on real bit changes.
module ps2_keypad
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [15:0] keys_o,
  output logic        key_event_o,
  output logic [3:0]  key_code_o,
  output logic        key_pressed_o,
  output logic        scan_valid_o,
  output logic [7:0]  scan_byte_o,
  output logic        frame_err_o
);

  logic       scan_valid, frame_err;
  logic [7:0] scan_byte;
  logic [4:0] map_res;

  logic [15:0] keys_q, keys_d;
  logic        event_q, event_d;
  logic [3:0]  code_q, code_d;
  logic        pressed_q, pressed_d;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_frame (
    .clk_i       (clk_i),
    .res_n_i     (res_n_i),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .scan_valid_o(scan_valid),
    .scan_byte_o (scan_byte),
    .frame_err_o (frame_err)
  );

  assign map_res = sc_to_key(scan_byte);

  always_comb begin
    keys_d    = keys_q;
    event_d   = 1'b0;
    code_d    = code_q;
    pressed_d = pressed_q;
    brk_d     = brk_q;
    ext_d     = ext_q;

    if (frame_err) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (scan_valid) begin
      if (scan_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (scan_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        // Typematic repeats and stray breaks leave the bit alone: no event.
        if (!ext_q && map_res[4] && (keys_q[map_res[3:0]] != !brk_q)) begin
          keys_d[map_res[3:0]] = !brk_q;
          event_d              = 1'b1;
          code_d               = map_res[3:0];
          pressed_d            = !brk_q;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      keys_q    <= 16'h0000;
      event_q   <= 1'b0;
      code_q    <= 4'h0;
      pressed_q <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
    end else begin
      keys_q    <= keys_d;
      event_q   <= event_d;
      code_q    <= code_d;
      pressed_q <= pressed_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
    end
  end

  assign keys_o        = keys_q;
  assign key_event_o   = event_q;
  assign key_code_o    = code_q;
  assign key_pressed_o = pressed_q;
  assign scan_valid_o  = scan_valid;
  assign scan_byte_o   = scan_byte;
  assign frame_err_o   = frame_err;

endmodule

// File: tb/tb_ps2_keypad.sv
// Randomised PS/2 frame stimulus against a keypad reference model.
module tb_ps2_keypad;

  localparam int unsigned TO   = 200;
  localparam int unsigned HALF = 16;

  logic        clk, res_n, ps2_clk, ps2_data;
  logic [15:0] keys;
  logic        key_event, key_pressed, scan_valid, frame_err;
  logic [3:0]  key_code;
  logic [7:0]  scan_byte;

  ps2_keypad #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .res_n_i      (res_n),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .keys_o       (keys),
    .key_event_o  (key_event),
    .key_code_o   (key_code),
    .key_pressed_o(key_pressed),
    .scan_valid_o (scan_valid),
    .scan_byte_o  (scan_byte),
    .frame_err_o  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Strobe monitor, sampled on the falling edge.
  int unsigned cyc = 0, sv_cyc = 0, ev_lat = 0;
  int unsigned act_sv = 0, act_err = 0, act_ev = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (scan_valid) begin act_sv++; sv_cyc = cyc; end
    if (frame_err) act_err++;
    if (key_event) begin act_ev++; ev_lat = cyc - sv_cyc; end
  end

  // Reference model: keypad index -> scan code.
  logic [7:0] kmap [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                            8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};
  logic [15:0] m_keys = 0;
  bit          m_brk = 0, m_ext = 0;
  int unsigned exp_sv = 0, exp_err = 0, exp_ev = 0, ev_before = 0;
  logic [7:0]  exp_byte = 0;
  logic [3:0]  exp_code = 0;
  logic        exp_pr = 0;

  function automatic int lookup(input logic [7:0] b);
    for (int k = 0; k < 16; k++) if (kmap[k] == b) return k;
    return -1;
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit good);
    int k;
    if (!good) begin
      exp_err++; m_brk = 0; m_ext = 0;
      return;
    end
    exp_sv++; exp_byte = b;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      k = lookup(b);
      if (!m_ext && k >= 0 && m_keys[k] != !m_brk) begin
        m_keys[k] = !m_brk; exp_ev++; exp_code = 4'(k); exp_pr = !m_brk;
      end
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".scan_valid_cnt"}, act_sv, exp_sv);
    check_eq({tag, ".frame_err_cnt"}, act_err, exp_err);
    check_eq({tag, ".scan_byte"}, 32'(scan_byte), 32'(exp_byte));
    check_eq({tag, ".keys"}, 32'(keys), 32'(m_keys));
    check_eq({tag, ".key_event_cnt"}, act_ev, exp_ev);
    check_eq({tag, ".key_code"}, 32'(key_code), 32'(exp_code));
    check_eq({tag, ".key_pressed"}, 32'(key_pressed), 32'(exp_pr));
    if (exp_ev != ev_before) check_eq({tag, ".event_latency"}, ev_lat, 1);
    ev_before = exp_ev;
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); ps2_data = bits[i];
      repeat (HALF) @(posedge clk); ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk); ps2_clk = 1'b1;
    end
  endtask

  // fault: 0 good, 1 parity flipped, 2 stop bit low
  task automatic send_byte(input logic [7:0] b, input int fault, input string tag);
    logic p, stop;
    p    = ~^b;
    if (fault == 1) p = ~p;
    stop = (fault == 2) ? 1'b0 : 1'b1;
    ps2_bits({stop, p, b, 1'b0}, 11);
    @(posedge clk); ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    model_frame(b, fault == 0);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    res_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    check_eq("reset.key_event", 32'(key_event), 0);
    res_n = 1'b1;
    repeat (4) @(posedge clk);

    send_byte(8'h1C, 0, "make1C");
    send_byte(8'hF0, 0, "brkpre");
    send_byte(8'h1C, 0, "brk1C");
    send_byte(8'h1C, 0, "rep1C_a");
    send_byte(8'h1C, 0, "rep1C_b");
    send_byte(8'hF0, 0, "brkpre2");
    send_byte(8'h1C, 0, "brk1C_2");
    send_byte(8'hE0, 0, "extpre");
    send_byte(8'h1C, 0, "ext1C");
    send_byte(8'h1C, 0, "plain1C");
    send_byte(8'hF0, 0, "brkpre3");
    send_byte(8'h22, 1, "bad22");
    send_byte(8'hF0, 0, "f0after");
    send_byte(8'h1C, 0, "brk1C_3");
    send_byte(8'h1C, 2, "badstop");

    // Timeout after start + 4 data bits, with a break prefix pending.
    send_byte(8'hF0, 0, "brkpre4");
    ps2_bits(11'b000_0000_1010, 5);
    repeat (TO + 20) @(posedge clk);
    model_frame(8'h00, 0);
    @(negedge clk);
    check_all("timeout");
    send_byte(8'h16, 0, "after_to");
    check_eq("after_to.key1", 32'(keys[1]), 1);

    // Reset mid-frame.
    send_byte(8'h2A, 0, "make2A");
    ps2_bits(11'b000_0011_0110, 5);
    @(negedge clk); res_n = 1'b0;
    #1;
    m_keys = 0; m_brk = 0; m_ext = 0; exp_byte = 0; exp_code = 0; exp_pr = 0;
    check_all("midreset");
    check_eq("midreset.strobes", 32'({scan_valid, frame_err, key_event}), 0);
    repeat (5) @(posedge clk);
    res_n = 1'b1;
    repeat (4) @(posedge clk);
    send_byte(8'h1E, 0, "after_rst");

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      b = kmap[$urandom_range(0, 15)];
      case (r)
        5: send_byte(8'hF0, 0, "rnd_f0");
        6: send_byte(8'hE0, 0, "rnd_e0");
        7: send_byte(8'($urandom), 0, "rnd_any");
        8: send_byte(b, 1, "rnd_par");
        9: send_byte(b, 2, "rnd_stop");
        default: send_byte(b, 0, "rnd_key");
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
